// File: rtl/memory_master_if.sv
// CPU-side request/response handshake bundle for memory_master.
// The shared memory bus (addr/we/oe/tristate data) stays on plain ports of the master.
interface memory_master_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_len;
    logic [DATA_W-1:0] wdata;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              done;

    modport master (
        input  req_valid, req_write, req_addr, req_len, wdata, wdata_valid,
        output req_ready, wdata_ready, rdata, rdata_valid, done
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len, wdata, wdata_valid,
        input  req_ready, wdata_ready, rdata, rdata_valid, done
    );
endinterface

// File: rtl/memory_master.sv
// Sequences read/write bursts from a valid/ready request port onto a shared tristate memory bus.
// Define MEMORY_MASTER_BURST_EN to honour req_len (1-16 beats); otherwise every request is one beat.
module memory_master #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    memory_master_if.master   bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_oe,
    inout  wire  [DATA_W-1:0] mem_data
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_LOAD, WR_DRIVE} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wr_data, wr_data_d, rdata_d;
    logic              req_ready_d, wdata_ready_d, rdata_valid_d, done_d;
    logic              mem_we_d, mem_oe_d;
    logic              accept_c, wr_hs_c, last_c, more_after_c;

    assign accept_c = (state == IDLE) && bus.req_valid && bus.req_ready;
    assign wr_hs_c  = (state == WR_LOAD) && bus.wdata_valid && bus.wdata_ready;

`ifdef MEMORY_MASTER_BURST_EN
    // Beats still to run after the current one
    logic [3:0] cnt, cnt_d;

    assign last_c       = (cnt == 4'd0);
    assign more_after_c = (cnt > 4'd1);

    always_comb begin
        cnt_d = cnt;
        if (accept_c) begin
            cnt_d = bus.req_len;
        end else if (!last_c && ((state == RD_DATA) || (state == WR_DRIVE))) begin
            cnt_d = cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 4'd0;
        else        cnt <= cnt_d;
    end
`else
    logic unused_req_len;

    assign unused_req_len = ^bus.req_len;
    assign last_c         = 1'b1;
    assign more_after_c   = 1'b0;
`endif

    // Master owns the data bus only while a write beat is being driven
    assign mem_data = mem_we ? wr_data : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            mem_addr        <= '0;
            mem_we          <= 1'b0;
            mem_oe          <= 1'b0;
            wr_data         <= '0;
            bus.req_ready   <= 1'b0;
            bus.wdata_ready <= 1'b0;
            bus.rdata       <= '0;
            bus.rdata_valid <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            state           <= state_d;
            mem_addr        <= addr_d;
            mem_we          <= mem_we_d;
            mem_oe          <= mem_oe_d;
            wr_data         <= wr_data_d;
            bus.req_ready   <= req_ready_d;
            bus.wdata_ready <= wdata_ready_d;
            bus.rdata       <= rdata_d;
            bus.rdata_valid <= rdata_valid_d;
            bus.done        <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:     if (accept_c) state_d = bus.req_write ? WR_LOAD : RD_ADDR;
            RD_ADDR:  state_d = RD_DATA;
            RD_DATA:  if (last_c) state_d = IDLE;
            WR_LOAD:  if (wr_hs_c) state_d = WR_DRIVE;
            WR_DRIVE: state_d = last_c ? IDLE : WR_LOAD;
            default:  state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; the address runs one beat ahead during reads
    always_comb begin
        addr_d        = mem_addr;
        wr_data_d     = wr_data;
        rdata_d       = bus.rdata;
        rdata_valid_d = 1'b0;
        done_d        = 1'b0;
        case (state)
            IDLE:    if (accept_c) addr_d = bus.req_addr;
            RD_ADDR: if (!last_c) addr_d = mem_addr + ADDR_W'(1);
            RD_DATA: begin
                rdata_d       = mem_data;
                rdata_valid_d = 1'b1;
                done_d        = last_c;
                if (more_after_c) addr_d = mem_addr + ADDR_W'(1);
            end
            WR_LOAD: if (wr_hs_c) wr_data_d = bus.wdata;
            WR_DRIVE: begin
                done_d = last_c;
                if (!last_c) addr_d = mem_addr + ADDR_W'(1);
            end
            default: ;
        endcase
        req_ready_d   = (state_d == IDLE);
        wdata_ready_d = (state_d == WR_LOAD);
        mem_we_d      = (state_d == WR_DRIVE);
        mem_oe_d      = (state_d == RD_DATA);
    end
endmodule

// File: tb/tb_memory_master.sv
// Randomised bench for memory_master: a memory model on the tristate bus plus a queue-based
// reference of expected write beats and read data, with directed scenarios pinning literal values.
module tb_memory_master;
`ifdef MEMORY_MASTER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] mem_addr;
    logic       mem_we, mem_oe;
    wire  [7:0] mem_data;

    memory_master_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    memory_master #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_oe   (mem_oe),
        .mem_data (mem_data)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_count = 0;
    int we_cycles = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 7 + 3);
    endfunction

    // Memory: registered read port, drives the bus only while mem_oe is high
    logic [7:0] mem [256];
    logic [7:0] mem_q;
    bit         mem_inited = 1'b0;

    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_inited <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
        mem_q <= mem[mem_addr];
    end

    assign mem_data = mem_oe ? mem_q : 8'bz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expected write beats, expected read data, committed memory image
    logic [7:0] ref_mem [256];
    bit         ref_inited = 1'b0;
    logic [7:0] exp_wa[$];
    logic [7:0] exp_wd[$];
    logic [7:0] exp_rd[$];
    logic [7:0] rd_got[$];
    int         rv_cyc[$];
    logic [7:0] wbuf [16];

    initial forever begin
        @(negedge clk);
        if (!ref_inited) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
            ref_inited = 1'b1;
        end
        check("bus_contention", 32'(mem_we && mem_oe), 32'd0);
        if (mem_we || mem_oe) check("bus_unknown", 32'($isunknown(mem_data)), 32'd0);
        if (mem_we) begin
            we_cycles++;
            check("write_expected", 32'(exp_wa.size() != 0), 32'd1);
            if (exp_wa.size() != 0) begin
                logic [7:0] a, d;
                a = exp_wa.pop_front();
                d = exp_wd.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(a));
                check("wr_data", 32'(mem_data), 32'(d));
                ref_mem[a] = d;
            end
        end
        if (bus.rdata_valid) begin
            check("read_expected", 32'(exp_rd.size() != 0), 32'd1);
            if (exp_rd.size() != 0) check("rdata", 32'(bus.rdata), 32'(exp_rd.pop_front()));
            rd_got.push_back(bus.rdata);
            rv_cyc.push_back(cyc);
        end
        if (bus.done) done_count++;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"},   32'(bus.req_ready),   32'd0);
        check({tag, "_wdata_ready"}, 32'(bus.wdata_ready), 32'd0);
        check({tag, "_rdata"},       32'(bus.rdata),       32'd0);
        check({tag, "_rdata_valid"}, 32'(bus.rdata_valid), 32'd0);
        check({tag, "_done"},        32'(bus.done),        32'd0);
        check({tag, "_mem_addr"},    32'(mem_addr),        32'd0);
        check({tag, "_mem_we"},      32'(mem_we),          32'd0);
        check({tag, "_mem_oe"},      32'(mem_oe),          32'd0);
    endtask

    // Returns at a negedge with req_ready high; c0 is the cycle number just after the accept edge
    task automatic wait_ready(output int c0);
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_timeout", 32'(n < 50), 32'd1);
        c0 = cyc + 1;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b0;
        check("done_timeout", 32'(n < 100), 32'd1);
    endtask

    task automatic issue(input bit wr, input logic [7:0] addr, input logic [3:0] len, input bit noise);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_len   = len;
        @(posedge clk);
        #1;
        bus.req_valid = noise;
        bus.req_write = 1'($urandom);
        bus.req_addr  = 8'($urandom);
        bus.req_len   = 4'($urandom);
    endtask

    task automatic write_beat(input logic [7:0] d, input int stall);
        int n = 0;
        @(negedge clk);
        while (!bus.wdata_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wdata_ready_timeout", 32'(n < 50), 32'd1);
        for (int k = 0; k < stall; k++) begin
            check("stall_no_we", 32'(mem_we), 32'd0);
            check("stall_wdata_ready", 32'(bus.wdata_ready), 32'd1);
            @(negedge clk);
        end
        bus.wdata       = d;
        bus.wdata_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.wdata_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [3:0] len, input int stall_beat,
                            input int stall, input bit noise);
        int beats, stalls, c0, dc0, wc0;
        beats  = BURST ? int'(len) + 1 : 1;
        stalls = (stall_beat < beats) ? stall : 0;
        for (int i = 0; i < beats; i++) begin
            exp_wa.push_back(8'(int'(addr) + i));
            exp_wd.push_back(wbuf[i]);
        end
        wait_ready(c0);
        dc0 = done_count;
        wc0 = we_cycles;
        issue(1'b1, addr, len, noise);
        for (int b = 0; b < beats; b++) write_beat(wbuf[b], (b == stall_beat) ? stall : 0);
        wait_done();
        check("wr_latency", 32'(cyc - c0), 32'(2 * beats + stalls));
        check("wr_ready_at_done", 32'(bus.req_ready), 32'd1);
        #1;
        check("wr_single_done", 32'(done_count - dc0), 32'd1);
        check("wr_we_cycles", 32'(we_cycles - wc0), 32'(beats));
        check("wr_queue_drained", 32'(exp_wa.size()), 32'd0);
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [3:0] len, input bit noise);
        int beats, c0, dc0;
        beats = BURST ? int'(len) + 1 : 1;
        for (int i = 0; i < beats; i++) exp_rd.push_back(ref_mem[8'(int'(addr) + i)]);
        rd_got.delete();
        rv_cyc.delete();
        wait_ready(c0);
        dc0 = done_count;
        issue(1'b0, addr, len, noise);
        wait_done();
        check("rd_latency", 32'(cyc - c0), 32'(beats + 1));
        check("rd_valid_with_done", 32'(bus.rdata_valid), 32'd1);
        check("rd_ready_at_done", 32'(bus.req_ready), 32'd1);
        #1;
        check("rd_single_done", 32'(done_count - dc0), 32'd1);
        check("rd_beat_count", 32'(rv_cyc.size()), 32'(beats));
        for (int i = 0; i < rv_cyc.size(); i++) check("rd_beat_cycle", 32'(rv_cyc[i] - c0), 32'(2 + i));
        check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    endtask

    task automatic reset_mid_burst();
        int c0, dc, rb;
        rb = BURST ? 1 : 0;
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        for (int i = 0; i <= rb; i++) begin
            exp_wa.push_back(8'(8'h40 + i));
            exp_wd.push_back(wbuf[i]);
        end
        wait_ready(c0);
        issue(1'b1, 8'h40, 4'd3, 1'b0);
        for (int b = 0; b <= rb; b++) write_beat(wbuf[b], 0);
        dc = done_count;
        check("rst_in_wr_drive", 32'(mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        exp_wa.delete();
        exp_wd.delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        check("rst_ready_before_edge", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("rst_ready_after_edge", 32'(bus.req_ready), 32'd1);
        check("rst_no_done", 32'(done_count - dc), 32'd0);
        check("rst_mem40_kept", 32'(mem[8'h40]), BURST ? 32'h11 : 32'h77);
        check("rst_mem41_untouched", 32'(mem[8'h41]), 32'h5A);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] pre [4];
        rst_n           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = '0;
        bus.req_len     = '0;
        bus.wdata       = '0;
        bus.wdata_valid = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        #1 rst_n = 1'b1;
        check("ready_before_first_edge", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("ready_after_first_edge", 32'(bus.req_ready), 32'd1);

        // Single write then read-back of 0x10
        wbuf[0] = 8'hA5;
        do_write(8'h10, 4'd0, 99, 0, 1'b0);
        check("mem_10_written", 32'(mem[8'h10]), 32'hA5);
        do_read(8'h10, 4'd0, 1'b0);
        check("rd_10_value", 32'(rd_got[0]), 32'hA5);

        // Wrapping burst read across 0xFF -> 0x00
        pre[0] = 8'h01; pre[1] = 8'h02; pre[2] = 8'h03; pre[3] = 8'h04;
        for (int i = 0; i < 4; i++) begin
            wbuf[0] = pre[i];
            do_write(8'(8'hFE + i), 4'd0, 99, 0, 1'b0);
        end
        do_read(8'hFE, 4'd3, 1'b1);
        check("wrap_rd_count", 32'(rd_got.size()), BURST ? 32'd4 : 32'd1);
        check("wrap_rd_0", 32'(rd_got[0]), 32'h01);
`ifdef MEMORY_MASTER_BURST_EN
        check("wrap_rd_1", 32'(rd_got[1]), 32'h02);
        check("wrap_rd_2", 32'(rd_got[2]), 32'h03);
        check("wrap_rd_3", 32'(rd_got[3]), 32'h04);
`endif

        // Burst write with a 3-cycle stall before the stalled beat, then read back
        for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
        do_write(8'h20, 4'd2, BURST ? 1 : 0, 3, 1'b1);
        check("stall_mem20", 32'(mem[8'h20]), 32'(wbuf[0]));
        do_read(8'h20, 4'd2, 1'b0);

        // Reset during the second write beat
        wbuf[0] = 8'h77;
        do_write(8'h40, 4'd0, 99, 0, 1'b0);
        wbuf[0] = 8'h5A;
        do_write(8'h41, 4'd0, 99, 0, 1'b0);
        reset_mid_burst();
        do_read(8'h40, 4'd1, 1'b0);
        check("rst_rd_40", 32'(rd_got[0]), BURST ? 32'h11 : 32'h77);

        // Random traffic around the wrap point
        for (int t = 0; t < 40; t++) begin
            ra = 8'(8'hF0 + $urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
                do_write(ra, 4'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                         1'($urandom));
            end else begin
                do_read(ra, 4'($urandom), 1'($urandom));
            end
        end

        check("final_wr_queue", 32'(exp_wa.size()), 32'd0);
        check("final_rd_queue", 32'(exp_rd.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/memory_master.md
# memory_master

Bus initiator for the 8-bit shared memory bus (`addr`, `we`, `oe`, bidirectional `data`). It accepts read/write requests from the CPU side over a valid/ready handshake and sequences the memory bus cycles. It returns read data as single-cycle pulses and guarantees the tristate `data` bus is never driven by both ends. It sits between the control unit and the 256x8 memory.

## Interface
- `ADDR_W`, 8, memory address width; the address space is 2^ADDR_W bytes.
- `DATA_W`, 8, data bus width.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_write` in 1: 1 = write burst, 0 = read burst.
- `req_addr` in ADDR_W: start address.
- `req_len` in 4: beats minus one (0 = 1 beat, 15 = 16 beats).
- `wdata` in DATA_W: write beat data.
- `wdata_valid` in 1: write beat present.
- `wdata_ready` out 1: block can take a write beat.
- `rdata` out DATA_W: read beat data.
- `rdata_valid` out 1: one-cycle pulse per read beat; no backpressure.
- `done` out 1: one-cycle pulse when the final beat completes.
- `mem_addr` out ADDR_W: memory address.
- `mem_we` out 1: memory write enable.
- `mem_oe` out 1: memory output enable.
- `mem_data` inout DATA_W: shared data bus.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_LOAD, WR_DRIVE. A request is accepted on an edge where `req_valid && req_ready`. The block latches `req_addr` and `req_len` into an address register and a beat counter.
- `req_ready` is registered and is 1 only in IDLE. `wdata_ready` is 1 only in WR_LOAD.
- RD_ADDR:
  - `mem_addr`=A, `mem_we`=0, `mem_oe`=0. The memory latches mem[A] at the next edge.
  - Always goes to RD_DATA.
- RD_DATA:
  - `mem_oe`=1 and `mem_we`=0.
  - Each edge captures `mem_data` into `rdata`, pulses `rdata_valid` in the following cycle, and decrements the counter.
  - `mem_addr` already presents A+1 while more beats remain, so the read is pipelined at one beat per cycle.
  - After the last capture the block goes to IDLE with `mem_oe`=0.
- WR_LOAD:
  - The block waits for `wdata_valid`.
  - On the handshake edge it latches `wdata` into a write register and sets `mem_we`=1, then goes to WR_DRIVE.
- WR_DRIVE:
  - The master drives `mem_data` from the write register, and the memory writes at the next edge.
  - At that edge `mem_we` returns to 0. The block goes to WR_LOAD with address+1 while beats remain, otherwise to IDLE.
- Bus ownership rules:
  - The master drives `mem_data` only when `mem_we`=1; otherwise it releases the bus to high-impedance.
  - `mem_we` and `mem_oe` are never both 1.
- Address arithmetic is modulo 2^ADDR_W, so 0xFF+1 wraps to 0x00.
- `done` is asserted in the cycle after the final memory edge. For reads it coincides with the last `rdata_valid`.

## Timing
- Reset values: `req_ready`=0, `wdata_ready`=0, `rdata`=0, `rdata_valid`=0, `done`=0, `mem_addr`=0, `mem_we`=0, `mem_oe`=0, `mem_data` released, state IDLE.
- `req_ready` rises at the first clk edge after `rst_n` deasserts.
- Read latency: with the request accepted at edge E0, the first `rdata_valid` is high in the cycle after E2. An N-beat read occupies N+1 bus cycles.
- Write throughput: at least 2 cycles per beat. Each cycle `wdata_valid` is low in WR_LOAD adds one cycle; `mem_we` stays 0 while stalled.
- The block does not return to IDLE (`req_ready`=1) until the cycle `done` pulses. No back-to-back overlap between requests.
- Reset asserted mid-burst: all outputs reach reset values immediately (asynchronously), and `mem_data` is released in the same cycle. The remaining beats are dropped without a `done` pulse. Memory locations already written stay written.
- `req_valid` while busy: ignored, and not accepted until `req_ready`=1.

## Configuration
- `MEMORY_MASTER_BURST_EN` defined:
  - `req_len` is honoured (1–16 beats), with address auto-increment and wrap.
- `MEMORY_MASTER_BURST_EN` undefined:
  - `req_len` is ignored and every request is exactly one beat.
  - The beat counter is not instantiated.
  - Reads take 2 bus cycles and writes 2 cycles plus stall.

## Test plan
- Single write: `req_write`=1, addr 0x10, `wdata` 0xA5 offered immediately. Required: `mem_we` high for exactly one cycle with `mem_data`=0xA5, memory[0x10]=0xA5 afterwards, and `done` 2 cycles after acceptance.
- Single read of 0x10 after that write: `rdata`=0xA5, with `rdata_valid` and `done` high in the same cycle, exactly in the cycle after E2.
- Burst read (BURST_EN): addr 0xFE, len 3, memory preloaded FE=01, FF=02, 00=03, 01=04. Required: `rdata_valid` on 4 consecutive cycles carrying 01,02,03,04; address wraps to 0x00.
- Burst write with stalls: len 2, `wdata_valid` deasserted 3 cycles before beat 2. Required: no `mem_we` during the stall, 3 correct locations written, and a single `done`.
- Reset mid-burst: `rst_n` pulled low during a WR_DRIVE cycle of beat 2 of 4. Required: `mem_we`/`mem_oe`=0 and bus released in the same cycle, no `done`, and `req_ready`=1 one edge after release.
- Contention check across all scenarios: the bench asserts `mem_we` and `mem_oe` are never both 1, and `mem_data` never resolves to X.
